// File: rtl/iq_power_avg.sv
// ---------------------------------------------------------------------------
// iq_power_avg
//
// Block-averaged signal-power estimator. Each accepted I/Q sample is squared
// and summed (I^2 + Q^2); 2^LOG2_N accepted samples are accumulated and the
// truncated block mean is presented with a one-cycle valid pulse. The output
// pair feeds the log2 stage of the 10log10(Power) dB chain.
//
// Parameters:
//   IQ_WIDTH  width of the signed I and Q samples (power is 2*IQ_WIDTH bits)
//   LOG2_N    log2 of the block length, legal range 0..8
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   enable_in  sample qualifier, I/Q accepted on each edge where it is high
//   clear_in   synchronous flush of the partial block and the pipeline
//   i_in       signed in-phase sample
//   q_in       signed quadrature sample
//   power_out  unsigned integer block-average power, held between updates
//   valid_out  one-cycle pulse marking a new power_out value
//
// Pipeline: square (stage 1) -> sum (stage 2) -> accumulate/divide (stage 3).
// A sample accepted at edge E produces its block result at edge E+2.
// ---------------------------------------------------------------------------
module iq_power_avg #(
   parameter int IQ_WIDTH = 16,
   parameter int LOG2_N   = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable_in,
   input  logic                         clear_in,
   input  logic signed [IQ_WIDTH-1:0]   i_in,
   input  logic signed [IQ_WIDTH-1:0]   q_in,
   output logic        [2*IQ_WIDTH-1:0] power_out,
   output logic                         valid_out
);

   localparam int PW    = 2 * IQ_WIDTH;
   localparam int ACC_W = PW + LOG2_N;
   localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;

   // Index of the last sample in a block; zero when every sample is a block.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

   logic signed [PW-1:0]    w_iSqFull;
   logic signed [PW-1:0]    w_qSqFull;
   logic        [ACC_W-1:0] w_accSum;
   logic                    w_lastSample;

   logic        [PW-1:0]    r_isq;
   logic        [PW-1:0]    r_qsq;
   logic                    r_v1;
   logic        [PW-1:0]    r_p2;
   logic                    r_v2;
   logic        [ACC_W-1:0] r_acc;
   logic        [CNT_W-1:0] r_cnt;

   // A signed square is never negative, so the product bits can be
   // reinterpreted as unsigned; the largest square (-2^(W-1))^2 still fits.
   assign w_iSqFull = i_in * i_in;
   assign w_qSqFull = q_in * q_in;

   // Running sum including the sample currently in stage 2. The extra
   // LOG2_N bits of headroom make a full block of full-scale samples safe.
   assign w_accSum     = r_acc + ACC_W'(r_p2);
   assign w_lastSample = (r_cnt == CNT_LAST);

   // Stage 1: square both components on an accepting edge. clear_in wins
   // over enable_in, so a sample presented alongside a clear is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_isq <= '0;
         r_qsq <= '0;
         r_v1  <= 1'b0;
      end else if (clear_in) begin
         r_v1  <= 1'b0;
      end else begin
         r_v1 <= enable_in;
         if (enable_in) begin
            r_isq <= $unsigned(w_iSqFull);
            r_qsq <= $unsigned(w_qSqFull);
         end
      end
   end

   // Stage 2: instantaneous power I^2 + Q^2. The maximum is 2^(PW-1), so
   // the PW-bit sum cannot wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_p2 <= '0;
         r_v2 <= 1'b0;
      end else if (clear_in) begin
         r_v2 <= 1'b0;
      end else begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_p2 <= r_isq + r_qsq;
         end
      end
   end

   // Stage 3: accumulate valid samples only, so enable gaps simply stretch
   // a block in time. On the last sample of a block the mean is taken by
   // dropping the low LOG2_N bits (truncation, no rounding) and the
   // accumulator restarts. power_out is deliberately left untouched by
   // clear_in so the downstream stage keeps its last estimate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         power_out <= '0;
         valid_out <= 1'b0;
      end else if (clear_in) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         valid_out <= 1'b0;
      end else if (r_v2) begin
         if (w_lastSample) begin
            power_out <= w_accSum[ACC_W-1:LOG2_N];
            valid_out <= 1'b1;
            r_acc     <= '0;
            r_cnt     <= '0;
         end else begin
            r_acc     <= w_accSum;
            r_cnt     <= r_cnt + CNT_W'(1);
            valid_out <= 1'b0;
         end
      end else begin
         valid_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_iq_power_avg.sv
// ---------------------------------------------------------------------------
// tb_iq_power_avg
//
// Scoreboard bench for iq_power_avg. Two instances are built: the default
// 16-sample averager and a LOG2_N=0 pass-through variant. Stimulus pushes
// the hand-computed result and the cycle on which the pulse must appear;
// a negedge monitor pops and compares whenever valid_out is seen, and
// also flags pulses that arrive early, late, or not at all.
// ---------------------------------------------------------------------------
module tb_iq_power_avg;

   typedef struct {
      logic [31:0] power;
      int          cyc;
   } exp_t;

   logic               clk;
   logic               rst;
   logic               enableIn;
   logic               clearIn;
   logic signed [15:0] iIn;
   logic signed [15:0] qIn;
   logic        [31:0] powerOut;
   logic               validOut;

   logic               enable0;
   logic signed [15:0] i0;
   logic signed [15:0] q0;
   logic        [31:0] power0;
   logic               valid0;

   exp_t expQ[$];
   exp_t expQ0[$];

   int cycleNum   = 0;
   int compared   = 0;
   int mismatched = 0;

   iq_power_avg #(.IQ_WIDTH(16), .LOG2_N(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable_in (enableIn),
      .clear_in  (clearIn),
      .i_in      (iIn),
      .q_in      (qIn),
      .power_out (powerOut),
      .valid_out (validOut)
   );

   iq_power_avg #(.IQ_WIDTH(16), .LOG2_N(0)) dut0 (
      .clk       (clk),
      .rst       (rst),
      .enable_in (enable0),
      .clear_in  (1'b0),
      .i_in      (i0),
      .q_in      (q0),
      .power_out (power0),
      .valid_out (valid0)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: runs on the falling edge, away from the active edge. Each
   // expected entry names the negedge count on which its pulse must show.
   always @(negedge clk) begin
      cycleNum = cycleNum + 1;
      if (!rst) begin
         if (expQ.size() > 0 && expQ[0].cyc < cycleNum) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL missingPulse16: no valid_out at cycle %0d, required power %0d", expQ[0].cyc, expQ[0].power);
            void'(expQ.pop_front());
         end
         if (validOut) begin
            compared++;
            if (expQ.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL unexpectedPulse16: valid_out at cycle %0d with power %0d, required none", cycleNum, powerOut);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               if (powerOut !== e.power || cycleNum != e.cyc) begin
                  mismatched++;
                  $display("[TB] FAIL pulse16: got power %0d at cycle %0d, required %0d at cycle %0d", powerOut, cycleNum, e.power, e.cyc);
               end
            end
         end
         if (expQ0.size() > 0 && expQ0[0].cyc < cycleNum) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL missingPulse1: no valid_out at cycle %0d, required power %0d", expQ0[0].cyc, expQ0[0].power);
            void'(expQ0.pop_front());
         end
         if (valid0) begin
            compared++;
            if (expQ0.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL unexpectedPulse1: valid_out at cycle %0d with power %0d, required none", cycleNum, power0);
            end else begin
               exp_t e;
               e = expQ0.pop_front();
               if (power0 !== e.power || cycleNum != e.cyc) begin
                  mismatched++;
                  $display("[TB] FAIL pulse1: got power %0d at cycle %0d, required %0d at cycle %0d", power0, cycleNum, e.power, e.cyc);
               end
            end
         end
      end
   end

   // Drive one cycle of inputs; returns 1 ns after the edge that samples them.
   task automatic applyStimulus(input logic en, input logic clr,
                                input logic signed [15:0] i, input logic signed [15:0] q);
      enableIn = en;
      clearIn  = clr;
      iIn      = i;
      qIn      = q;
      @(posedge clk);
      #1;
      enableIn = 1'b0;
      clearIn  = 1'b0;
   endtask

   // Called right after the accept edge of a block's last sample.
   task automatic pushExpected(input logic [31:0] p);
      exp_t e;
      e.power = p;
      e.cyc   = cycleNum + 3;
      expQ.push_back(e);
   endtask

   task automatic sendBlock(input int n, input logic signed [15:0] i, input logic signed [15:0] q,
                            input bit gap, input bit push, input logic [31:0] p);
      for (int k = 0; k < n; k++) begin
         applyStimulus(1'b1, 1'b0, i, q);
         if (push && k == n - 1) pushExpected(p);
         if (gap) applyStimulus(1'b0, 1'b0, 16'sd0, 16'sd0);
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      compared++;
      if (actual !== required) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d (0x%08h), required %0d (0x%08h)", name, actual, actual, required, required);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 16'sd0, 16'sd0);
   endtask

   initial begin
      rst      = 1'b1;
      enableIn = 1'b0;
      clearIn  = 1'b0;
      iIn      = '0;
      qIn      = '0;
      enable0  = 1'b0;
      i0       = '0;
      q0       = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetPower", powerOut, 32'd0);
      checkOutput("resetValid", {31'd0, validOut}, 32'd0);
      rst = 1'b0;
      idle(2);

      // Constant tone: 3^2 + 4^2 = 25, two back-to-back blocks 16 cycles apart
      sendBlock(16, 16'sd3, 16'sd4, 1'b0, 1'b1, 32'd25);
      sendBlock(16, 16'sd3, 16'sd4, 1'b0, 1'b1, 32'd25);
      idle(4);

      // Full scale: 2 * 2^30 = 2^31 without wrap; then 32767^2 = 1073676289
      sendBlock(16, -16'sd32768, -16'sd32768, 1'b0, 1'b1, 32'h8000_0000);
      sendBlock(16, 16'sd32767, 16'sd0, 1'b0, 1'b1, 32'd1073676289);

      // Clear with a colliding sample: partial block and sample both dropped
      sendBlock(8, 16'sd10, 16'sd0, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b1, 16'sd100, 16'sd100);
      checkOutput("clearHoldsPower", powerOut, 32'd1073676289);
      checkOutput("clearValidLow", {31'd0, validOut}, 32'd0);
      sendBlock(16, 16'sd2, 16'sd2, 1'b0, 1'b1, 32'd8);
      idle(4);

      // Truncation with gaps: block sum 10, 10 >> 4 = 0
      sendBlock(15, 16'sd0, 16'sd0, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b0, 16'sd1, 16'sd3);
      pushExpected(32'd0);
      idle(4);

      // Establish a nonzero output, then reset asynchronously mid-block
      sendBlock(16, 16'sd1, 16'sd2, 1'b0, 1'b1, 32'd5);
      idle(4);
      sendBlock(5, 16'sd7, 16'sd7, 1'b0, 1'b0, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("asyncResetPower", powerOut, 32'd0);
      checkOutput("asyncResetValid", {31'd0, validOut}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      // Discarded partial block must not leak: sixteen (1,0) average to 1
      sendBlock(16, 16'sd1, 16'sd0, 1'b0, 1'b1, 32'd1);
      idle(4);

      // Single-sample blocks: (1,1)->2, (-5,12)->169, (0,0)->0 back to back
      enable0 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp_t e;
         case (k)
            0: begin i0 = 16'sd1;  q0 = 16'sd1;  e.power = 32'd2;   end
            1: begin i0 = -16'sd5; q0 = 16'sd12; e.power = 32'd169; end
            default: begin i0 = 16'sd0; q0 = 16'sd0; e.power = 32'd0; end
         endcase
         @(posedge clk);
         #1;
         e.cyc = cycleNum + 3;
         expQ0.push_back(e);
      end
      enable0 = 1'b0;
      idle(8);

      checkOutput("pendingAvg16", expQ.size(), 32'd0);
      checkOutput("pendingAvg1", expQ0.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Safety net against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not complete, required finish before 200000 ns");
      $fatal(1, "[TB] timeout");
   end

endmodule
